// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory program loader.
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   LANE_W         : width of the byte-lane counter inside a word
//   WORD_W         : packed word width in bits
//   ST_*           : loader FSM state encodings
package imem_loader_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
   localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
   localparam int unsigned STATE_W        = 3;

   // Loader FSM states
   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_LEN   = 3'd1;
   localparam logic [STATE_W-1:0] ST_DATA  = 3'd2;
   localparam logic [STATE_W-1:0] ST_WRITE = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;
   localparam logic [STATE_W-1:0] ST_ERR   = 3'd5;

endpackage : imem_loader_pkg

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word packer shared by the length and data phases.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : restart packing at lane 0 with an all-zero word
//   strobe_i      : byte_i is accepted this cycle
//   byte_i        : stream byte, lane k lands in bits [8k+7:8k]
//   word_c_o      : current word with this cycle's byte already merged
//   last_c_o      : this cycle's byte completes a word
module word_packer
   import imem_loader_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              strobe_i,
   input  logic [7:0]        byte_i,
   output logic [WORD_W-1:0] word_c_o,
   output logic              last_c_o
);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [WORD_W-1:0] word_q, word_d;

   // Merge the incoming byte into its lane; lane counter wraps after a full word
   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      if (clear_i) begin
         lane_d = '0;
         word_d = '0;
      end else if (strobe_i) begin
         word_d[{lane_q, 3'b000} +: 8] = byte_i;
         lane_d                        = lane_q + LANE_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lane_q <= '0;
         word_q <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

   // The merged view lets the caller act on a word in the same cycle its last byte arrives
   assign word_c_o = word_d;
   assign last_c_o = strobe_i && !clear_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

endmodule : word_packer

// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a length-prefixed little-endian byte
// stream, packs it into words, writes them into instruction memory and holds
// the core in reset until the whole program has been loaded.
// Ports:
//   clk_i, rst_ni      : clock, async active-low reset
//   start_i            : begin a load (honoured in IDLE, DONE, ERR)
//   byte_valid_i/byte_i: stream byte and its valid
//   byte_ready_o       : loader accepts a byte this cycle (LEN/DATA)
//   imem_we_o          : one-cycle instruction memory write strobe
//   imem_addr_o        : write byte address, BASE_ADDR + 4*index
//   imem_wdata_o       : assembled instruction word
//   cpu_rst_o          : active-high core reset, low only in DONE
//   busy_o             : load in progress (LEN, DATA, WRITE)
//   done_o             : last load completed
//   err_o              : last load rejected, length exceeded DEPTH_WORDS
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           DEPTH_WORDS = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  byte_valid_i,
   input  logic [7:0]            byte_i,
   output logic                  byte_ready_o,
   output logic                  imem_we_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   output logic [DATA_WIDTH-1:0] imem_wdata_o,
   output logic                  cpu_rst_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int unsigned CNT_W   = 32;
   localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH_WORDS);

   logic [STATE_W-1:0]    state_q, state_d;
   logic [CNT_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      len_q, len_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  ready_q, ready_d;
   logic                  we_q, we_d;
   logic                  cpu_rst_q, cpu_rst_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  pk_clear_c;
   logic                  pk_strobe_c;
   logic [WORD_W-1:0]     pk_word_c;
   logic                  pk_last_c;

   // ready_q is high exactly in LEN/DATA, so this is the byte handshake
   assign pk_strobe_c = byte_valid_i && ready_q;

   word_packer u_packer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (pk_clear_c),
      .strobe_i (pk_strobe_c),
      .byte_i   (byte_i),
      .word_c_o (pk_word_c),
      .last_c_o (pk_last_c)
   );

   // Next-state, counters and registered-output next values
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      len_d      = len_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      pk_clear_c = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_i) begin
               state_d    = ST_LEN;
               idx_d      = '0;
               len_d      = '0;
               pk_clear_c = 1'b1;
            end
         end
         ST_LEN: begin
            if (pk_last_c) begin
               len_d = CNT_W'(pk_word_c);
               if (CNT_W'(pk_word_c) == '0) begin
                  state_d = ST_DONE;
               end else if (CNT_W'(pk_word_c) > DEPTH_N) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (pk_last_c) begin
               state_d = ST_WRITE;
               // Address wraps modulo 2^ADDR_WIDTH
               addr_d  = BASE_ADDR + (ADDR_WIDTH'(idx_q) << 2);
               wdata_d = DATA_WIDTH'(pk_word_c);
            end
         end
         ST_WRITE: begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = (idx_q == len_q - CNT_W'(1)) ? ST_DONE : ST_DATA;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status outputs track the state being entered so they align with it
      ready_d   = (state_d == ST_LEN) || (state_d == ST_DATA);
      we_d      = (state_d == ST_WRITE);
      busy_d    = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_WRITE);
      done_d    = (state_d == ST_DONE);
      err_d     = (state_d == ST_ERR);
      cpu_rst_d = (state_d != ST_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         len_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ready_q   <= 1'b0;
         we_q      <= 1'b0;
         cpu_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ready_q   <= ready_d;
         we_q      <= we_d;
         cpu_rst_q <= cpu_rst_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign byte_ready_o = ready_q;
   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign cpu_rst_o    = cpu_rst_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader with a byte-stream reference model.
module tb_imem_loader;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 1024;
   localparam logic [AW-1:0] BASE = 32'h0000_0000;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          bvalid;
   logic [7:0]    bdata;
   logic          ready;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          cpu_rst;
   logic          busy;
   logic          done;
   logic          err;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;

   logic [7:0]  stream_q[$];
   logic [7:0]  acc_q[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int unsigned wr_cyc_q[$];
   int unsigned hs_cyc_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   int unsigned exp_last_q[$];
   bit          exp_err;

   imem_loader #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .byte_valid_i (bvalid),
      .byte_i       (bdata),
      .byte_ready_o (ready),
      .imem_we_o    (we),
      .imem_addr_o  (addr),
      .imem_wdata_o (wdata),
      .cpu_rst_o    (cpu_rst),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Observe accepted bytes and memory writes away from the active edge
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bvalid === 1'b1 && ready === 1'b1) acc_q.push_back(bdata);
         if (we === 1'b1) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wdata);
            wr_cyc_q.push_back(cyc);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model and stimulus helpers ----------------

   function automatic void push_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) stream_q.push_back(w[8*b +: 8]);
   endfunction

   // Expected writes straight from the stream format: LE length, then LE words
   function automatic void build_model();
      logic [31:0] n;
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_last_q.delete();
      n = {stream_q[3], stream_q[2], stream_q[1], stream_q[0]};
      exp_err = (n > DEPTH);
      if (!exp_err) begin
         for (int k = 0; k < int'(n); k++) begin
            exp_addr_q.push_back(BASE + 32'(4 * k));
            exp_data_q.push_back({stream_q[4+4*k+3], stream_q[4+4*k+2],
                                  stream_q[4+4*k+1], stream_q[4+4*k]});
            exp_last_q.push_back(32'(4 + 4 * k + 3));
         end
      end
   endfunction

   function automatic int byte_diffs();
      int d = 0;
      if (acc_q.size() != stream_q.size()) return 1 + acc_q.size();
      for (int i = 0; i < stream_q.size(); i++) if (acc_q[i] !== stream_q[i]) d++;
      return d;
   endfunction

   task automatic clear_obs();
      acc_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      hs_cyc_q.delete();
   endtask

   // Start pulse with a junk byte offered in the same cycle; it must not be taken
   task automatic do_start();
      start  = 1'b1;
      bvalid = 1'b1;
      bdata  = 8'hEE;
      @(posedge clk); #1;
      start  = 1'b0;
      bvalid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap_pct);
      int guard = 0;
      while ($urandom_range(99) < gap_pct) begin
         bvalid = 1'b0;
         bdata  = 8'($urandom);
         @(posedge clk); #1;
      end
      bvalid = 1'b1;
      bdata  = b;
      forever begin
         @(negedge clk);
         if (ready === 1'b1) break;
         guard++;
         if (guard > 200) begin
            n_checks++; n_fail++;
            $display("FAIL handshake_timeout: ready stayed %b expected 1", ready);
            break;
         end
      end
      @(posedge clk); #1;
      hs_cyc_q.push_back(cyc);
      bvalid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      @(negedge clk);
      while (busy !== 1'b0) begin
         @(negedge clk);
         guard++;
         if (guard > 100) begin
            n_checks++; n_fail++;
            $display("FAIL busy_timeout: busy=%b expected 0", busy);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   // Full load of stream_q; start_at >= 0 injects an ignored start before that byte
   task automatic run_load(input int unsigned gap_pct, input int start_at);
      clear_obs();
      build_model();
      do_start();
      for (int i = 0; i < stream_q.size(); i++) begin
         if (i == start_at) pulse_start();
         send_byte(stream_q[i], gap_pct);
      end
      wait_idle();
   endtask

   // ---------------- tests ----------------

   task automatic test_reset();
      rst_n = 1'b1; start = 1'b0; bvalid = 1'b0; bdata = 8'h00;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({cpu_rst, ready, we, done, err, busy} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_outputs: got {rst,rdy,we,done,err,busy}=%b expected 100000",
                  {cpu_rst, ready, we, done, err, busy});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({cpu_rst, ready, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL idle_outputs: got {rst,rdy,busy}=%b expected 100", {cpu_rst, ready, busy});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      stream_q.delete();
      push_word(32'd2); push_word(32'h0010_0513); push_word(32'h0020_0593);
      run_load(0, -1);
      n_checks++;
      if (wr_addr_q.size() != 2) begin
         n_fail++; $display("FAIL basic_nwrites: got %0d expected 2", wr_addr_q.size());
      end else begin
         n_checks++;
         if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h0010_0513) begin
            n_fail++; $display("FAIL basic_w0: got %h@%h expected 00100513@00000000", wr_data_q[0], wr_addr_q[0]);
         end
         n_checks++;
         if (wr_addr_q[1] !== 32'h4 || wr_data_q[1] !== 32'h0020_0593) begin
            n_fail++; $display("FAIL basic_w1: got %h@%h expected 00200593@00000004", wr_data_q[1], wr_addr_q[1]);
         end
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (wr_cyc_q[k] !== hs_cyc_q[exp_last_q[k]]) begin
               n_fail++; $display("FAIL basic_latency%0d: we at cycle %0d expected %0d", k, wr_cyc_q[k], hs_cyc_q[exp_last_q[k]]);
            end
         end
      end
      n_checks++;
      if (byte_diffs() != 0) begin
         n_fail++; $display("FAIL basic_bytes: got %0d accepted expected %0d", acc_q.size(), stream_q.size());
      end
      n_checks++;
      if ({done, err, cpu_rst, busy} !== 4'b1000) begin
         n_fail++; $display("FAIL basic_status: got {done,err,rst,busy}=%b expected 1000", {done, err, cpu_rst, busy});
      end
   endtask

   task automatic test_gapped(input int unsigned n_words, input int start_at);
      stream_q.delete();
      push_word(n_words);
      for (int k = 0; k < int'(n_words); k++) push_word($urandom);
      run_load(40, start_at);
      n_checks++;
      if (wr_addr_q.size() != exp_addr_q.size()) begin
         n_fail++; $display("FAIL gap_nwrites: got %0d expected %0d", wr_addr_q.size(), exp_addr_q.size());
      end else begin
         for (int k = 0; k < exp_addr_q.size(); k++) begin
            n_checks++;
            if (wr_addr_q[k] !== exp_addr_q[k] || wr_data_q[k] !== exp_data_q[k]) begin
               n_fail++; $display("FAIL gap_w%0d: got %h@%h expected %h@%h", k, wr_data_q[k], wr_addr_q[k], exp_data_q[k], exp_addr_q[k]);
            end
            n_checks++;
            if (wr_cyc_q[k] !== hs_cyc_q[exp_last_q[k]]) begin
               n_fail++; $display("FAIL gap_latency%0d: we at cycle %0d expected %0d", k, wr_cyc_q[k], hs_cyc_q[exp_last_q[k]]);
            end
         end
      end
      n_checks++;
      if (byte_diffs() != 0) begin
         n_fail++; $display("FAIL gap_bytes: got %0d accepted expected %0d", acc_q.size(), stream_q.size());
      end
      n_checks++;
      if ({done, cpu_rst} !== 2'b10) begin
         n_fail++; $display("FAIL gap_status: got {done,rst}=%b expected 10", {done, cpu_rst});
      end
   endtask

   task automatic test_too_long();
      stream_q.delete();
      push_word(DEPTH + 1);
      run_load(0, -1);
      n_checks++;
      if ({err, done, cpu_rst, busy} !== 4'b1010 || wr_addr_q.size() != 0 || !exp_err) begin
         n_fail++; $display("FAIL toolong_status: got {err,done,rst,busy}=%b writes=%0d expected 1010 writes=0",
                            {err, done, cpu_rst, busy}, wr_addr_q.size());
      end
      // Recovery from ERR with a valid program
      stream_q.delete();
      push_word(32'd1); push_word(32'hDEAD_BEEF);
      run_load(20, -1);
      n_checks++;
      if (wr_addr_q.size() != 1 || wr_data_q[0] !== 32'hDEAD_BEEF || wr_addr_q[0] !== BASE) begin
         n_fail++; $display("FAIL recover_write: got %0d writes first %h expected 1 write deadbeef", wr_addr_q.size(), wr_data_q[0]);
      end
      n_checks++;
      if ({err, done, cpu_rst} !== 3'b010) begin
         n_fail++; $display("FAIL recover_status: got {err,done,rst}=%b expected 010", {err, done, cpu_rst});
      end
   endtask

   task automatic test_zero();
      stream_q.delete();
      push_word(32'd0);
      clear_obs();
      do_start();
      for (int i = 0; i < 4; i++) send_byte(stream_q[i], 0);
      @(negedge clk);
      n_checks++;
      if ({done, busy, cpu_rst, err} !== 4'b1000 || wr_addr_q.size() != 0) begin
         n_fail++; $display("FAIL zero_len: got {done,busy,rst,err}=%b writes=%0d expected 1000 writes=0",
                            {done, busy, cpu_rst, err}, wr_addr_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      stream_q.delete();
      push_word(32'd2); push_word(32'h1111_2222); push_word(32'h3333_4444);
      clear_obs();
      do_start();
      for (int i = 0; i < 10; i++) send_byte(stream_q[i], 0);
      pulse_start();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL midload_busy: got %b expected 1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cpu_rst, busy, ready, we, done} !== 5'b10000) begin
         n_fail++; $display("FAIL midreset_outputs: got {rst,busy,rdy,we,done}=%b expected 10000",
                            {cpu_rst, busy, ready, we, done});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      bvalid = 1'b1; bdata = 8'h5A;
      repeat (4) @(posedge clk);
      #1 bvalid = 1'b0;
      n_checks++;
      if (wr_addr_q.size() != 1 || wr_data_q[0] !== 32'h1111_2222 || acc_q.size() != 10) begin
         n_fail++; $display("FAIL midreset_writes: got %0d writes %0d bytes expected 1 writes 10 bytes",
                            wr_addr_q.size(), acc_q.size());
      end
      n_checks++;
      if ({busy, done, cpu_rst} !== 3'b001) begin
         n_fail++; $display("FAIL midreset_idle: got {busy,done,rst}=%b expected 001", {busy, done, cpu_rst});
      end
   endtask

   task automatic test_max_depth();
      int bad = 0;
      stream_q.delete();
      push_word(DEPTH);
      for (int k = 0; k < int'(DEPTH); k++) push_word($urandom);
      run_load(0, -1);
      n_checks++;
      if (wr_addr_q.size() != DEPTH) begin
         n_fail++; $display("FAIL max_nwrites: got %0d expected %0d", wr_addr_q.size(), DEPTH);
      end else begin
         for (int k = 0; k < int'(DEPTH); k++)
            if (wr_addr_q[k] !== exp_addr_q[k] || wr_data_q[k] !== exp_data_q[k]) bad++;
         n_checks++;
         if (bad != 0) begin
            n_fail++; $display("FAIL max_data: got %0d bad writes expected 0", bad);
         end
         n_checks++;
         if (wr_addr_q[DEPTH-1] !== 32'h0000_0FFC) begin
            n_fail++; $display("FAIL max_last_addr: got %h expected 00000ffc", wr_addr_q[DEPTH-1]);
         end
      end
      n_checks++;
      if ({done, err, cpu_rst} !== 3'b100) begin
         n_fail++; $display("FAIL max_status: got {done,err,rst}=%b expected 100", {done, err, cpu_rst});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped(2, -1);
      test_gapped(32'($urandom_range(3, 6)), 9);
      test_too_long();
      test_zero();
      test_reset_mid();
      test_gapped(32'($urandom_range(1, 4)), -1);
      test_max_depth();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_imem_loader
